// File: rtl/qpu_exu_evt_tq_if.sv
// Push handshake between the QIU write-back stage and the event timing queue.
interface qpu_exu_evt_tq_if #(
    parameter int EDATA_W = 48,
    parameter int OPR_W   = 9,
    parameter int TIME_W  = 32
);
    logic               tq_i_valid;
    logic               tq_i_ready;
    logic [EDATA_W-1:0] tq_i_edata;
    logic [OPR_W-1:0]   tq_i_oprand;
    logic [TIME_W-1:0]  tq_i_tdata;

    modport master (
        output tq_i_valid,
        output tq_i_edata,
        output tq_i_oprand,
        output tq_i_tdata,
        input  tq_i_ready
    );

    modport slave (
        input  tq_i_valid,
        input  tq_i_edata,
        input  tq_i_oprand,
        input  tq_i_tdata,
        output tq_i_ready
    );
endinterface

// File: rtl/qpu_exu_evt_tq.sv
// Event timing queue: buffers timestamped events and fires each one
// when the local timeline reaches its timestamp, flagging late events.
module qpu_exu_evt_tq #(
    parameter int EDATA_W = 48,
    parameter int OPR_W   = 9,
    parameter int TIME_W  = 32,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    qpu_exu_evt_tq_if.slave            tq_i,
    input  logic                       tq_start,
    input  logic                       tq_stop,
    input  logic                       tq_flush,
    output logic                       tq_o_evt_valid,
    output logic [EDATA_W-1:0]         tq_o_evt_edata,
    output logic [OPR_W-1:0]           tq_o_evt_oprand,
    output logic                       tq_o_late,
    output logic                       tq_o_late_sticky,
    output logic [TIME_W-1:0]          tq_o_timer,
    output logic [$clog2(DEPTH):0]     tq_o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [TIME_W-1:0]  mem_t [DEPTH];
    logic [OPR_W-1:0]   mem_o [DEPTH];
    logic [EDATA_W-1:0] mem_e [DEPTH];

    logic               push;
    logic               fire;
    logic               late;
    logic [TIME_W-1:0]  diff;

    assign tq_i.tq_i_ready = (tq_o_count != CW'(DEPTH)) & ~tq_flush;
    assign push = tq_i.tq_i_valid & tq_i.tq_i_ready;

    // Modular distance to the head timestamp; MSB set means already passed.
    assign diff = mem_t[rptr] - tq_o_timer;
    assign fire = (state == RUN) & (tq_o_count != '0) & ~tq_flush
                & ((diff == '0) | diff[TIME_W-1]);
    assign late = fire & diff[TIME_W-1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_t[wptr] <= tq_i.tq_i_tdata;
            mem_o[wptr] <= tq_i.tq_i_oprand;
            mem_e[wptr] <= tq_i.tq_i_edata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            tq_o_timer       <= '0;
            wptr             <= '0;
            rptr             <= '0;
            tq_o_count       <= '0;
            tq_o_evt_valid   <= 1'b0;
            tq_o_evt_edata   <= '0;
            tq_o_evt_oprand  <= '0;
            tq_o_late        <= 1'b0;
            tq_o_late_sticky <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (tq_start && !tq_stop) state <= RUN;
                RUN: begin
                    tq_o_timer <= tq_o_timer + 1'b1;
                    if (tq_stop) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            tq_o_evt_valid <= fire;
            tq_o_late      <= late;
            if (fire) begin
                tq_o_evt_edata  <= mem_e[rptr];
                tq_o_evt_oprand <= mem_o[rptr];
            end

            if (tq_flush) begin
                wptr             <= '0;
                rptr             <= '0;
                tq_o_count       <= '0;
                tq_o_late_sticky <= 1'b0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (fire) rptr <= rptr + 1'b1;
                if (late) tq_o_late_sticky <= 1'b1;
                unique case ({push, fire})
                    2'b10:   tq_o_count <= tq_o_count + 1'b1;
                    2'b01:   tq_o_count <= tq_o_count - 1'b1;
                    default: tq_o_count <= tq_o_count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qpu_exu_evt_tq.sv
// Directed testbench for qpu_exu_evt_tq with an 8-bit timeline.
module tb_qpu_exu_evt_tq;
    localparam int EDATA_W = 48;
    localparam int OPR_W   = 9;
    localparam int TIME_W  = 8;
    localparam int DEPTH   = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic tq_start, tq_stop, tq_flush;
    logic                evt_valid;
    logic [EDATA_W-1:0]  evt_edata;
    logic [OPR_W-1:0]    evt_oprand;
    logic                late, sticky;
    logic [TIME_W-1:0]   timer;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int passed = 0;

    qpu_exu_evt_tq_if #(.EDATA_W(EDATA_W), .OPR_W(OPR_W), .TIME_W(TIME_W)) tq_if ();

    qpu_exu_evt_tq #(
        .EDATA_W(EDATA_W), .OPR_W(OPR_W), .TIME_W(TIME_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tq_i(tq_if),
        .tq_start(tq_start), .tq_stop(tq_stop), .tq_flush(tq_flush),
        .tq_o_evt_valid(evt_valid), .tq_o_evt_edata(evt_edata),
        .tq_o_evt_oprand(evt_oprand), .tq_o_late(late),
        .tq_o_late_sticky(sticky), .tq_o_timer(timer), .tq_o_count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [EDATA_W-1:0] e, input logic [OPR_W-1:0] o,
                        input logic [TIME_W-1:0] t);
        tq_if.tq_i_valid  = 1'b1;
        tq_if.tq_i_edata  = e;
        tq_if.tq_i_oprand = o;
        tq_if.tq_i_tdata  = t;
        tick();
        tq_if.tq_i_valid  = 1'b0;
    endtask

    task automatic start();
        tq_start = 1'b1;
        tick();
        tq_start = 1'b0;
    endtask

    // Bounded wait for a fire strobe; an expired bound is a failed check.
    task automatic wait_fire(input string name, input int bound);
        int n = 0;
        while (!evt_valid && n < bound) begin
            tick();
            n++;
        end
        total++;
        if (evt_valid !== 1'b1)
            $display("FAIL %s: no fire within %0d cycles, valid=%b required 1", name, bound, evt_valid);
        else
            passed++;
    endtask

    task automatic wait_timer(input logic [TIME_W-1:0] t);
        int n = 0;
        while (timer !== t && n < 400) begin
            tick();
            n++;
        end
        total++;
        if (timer !== t)
            $display("FAIL wait_timer: timer=%0d required %0d", timer, t);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({evt_valid, late, sticky, evt_edata, evt_oprand, timer, count} !== '0)
            $display("FAIL reset_outputs: valid=%b late=%b sticky=%b edata=%h opr=%h timer=%0d count=%0d required all 0",
                     evt_valid, late, sticky, evt_edata, evt_oprand, timer, count);
        else passed++;
        total++;
        if (tq_if.tq_i_ready !== 1'b1)
            $display("FAIL reset_ready: ready=%b required 1", tq_if.tq_i_ready);
        else passed++;
        tick();
        total++;
        if (timer !== 8'd0)
            $display("FAIL reset_idle_timer: timer=%0d required 0", timer);
        else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        push(48'hABCD_0000_1234, 9'h1A5, 8'd10);
        total++;
        if (count !== 4'd1) $display("FAIL basic_count1: count=%0d required 1", count);
        else passed++;
        start();
        wait_fire("basic_fire", 40);
        total++;
        if (timer !== 8'd11) $display("FAIL basic_timer: timer=%0d required 11", timer);
        else passed++;
        total++;
        if (evt_edata !== 48'hABCD_0000_1234 || evt_oprand !== 9'h1A5)
            $display("FAIL basic_data: edata=%h opr=%h required abcd00001234 1a5", evt_edata, evt_oprand);
        else passed++;
        total++;
        if (late !== 1'b0 || count !== 4'd0)
            $display("FAIL basic_late_count: late=%b count=%0d required 0 0", late, count);
        else passed++;
        tick();
        total++;
        if (evt_valid !== 1'b0 || evt_edata !== 48'hABCD_0000_1234)
            $display("FAIL basic_hold: valid=%b edata=%h required 0 abcd00001234", evt_valid, evt_edata);
        else passed++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) push(48'(i + 16), 9'(i), 8'(100 + i));
        total++;
        if (count !== 4'd8 || tq_if.tq_i_ready !== 1'b0)
            $display("FAIL full_state: count=%0d ready=%b required 8 0", count, tq_if.tq_i_ready);
        else passed++;
        tq_if.tq_i_valid = 1'b1;
        tq_if.tq_i_tdata = 8'd200;
        tick();
        tq_if.tq_i_valid = 1'b0;
        total++;
        if (count !== 4'd8) $display("FAIL full_holdoff: count=%0d required 8", count);
        else passed++;
        start();
        wait_fire("full_first", 200);
        total++;
        if (timer !== 8'd101 || tq_if.tq_i_ready !== 1'b1)
            $display("FAIL full_first_pop: timer=%0d ready=%b required 101 1", timer, tq_if.tq_i_ready);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (evt_valid !== 1'b1 || evt_edata !== 48'(i + 16) || late !== 1'b0)
                $display("FAIL full_order%0d: valid=%b edata=%0d late=%b required 1 %0d 0",
                         i, evt_valid, evt_edata, late, i + 16);
            else passed++;
            tick();
        end
        total++;
        if (evt_valid !== 1'b0 || count !== 4'd0)
            $display("FAIL full_drain: valid=%b count=%0d required 0 0", evt_valid, count);
        else passed++;
    endtask

    task automatic test_late_flush();
        do_reset();
        start();
        wait_timer(8'd50);
        push(48'h55, 9'h3, 8'd20);
        wait_fire("late_fire", 10);
        total++;
        if (late !== 1'b1 || sticky !== 1'b1 || evt_edata !== 48'h55)
            $display("FAIL late_flags: late=%b sticky=%b edata=%h required 1 1 55", late, sticky, evt_edata);
        else passed++;
        tick();
        total++;
        if (late !== 1'b0 || sticky !== 1'b1)
            $display("FAIL late_pulse: late=%b sticky=%b required 0 1", late, sticky);
        else passed++;
        push(48'h66, 9'h4, timer + 8'd100);
        total++;
        if (count !== 4'd1) $display("FAIL flush_pre_count: count=%0d required 1", count);
        else passed++;
        tq_flush = 1'b1;
        #1;
        total++;
        if (tq_if.tq_i_ready !== 1'b0) $display("FAIL flush_ready: ready=%b required 0", tq_if.tq_i_ready);
        else passed++;
        tick();
        tq_flush = 1'b0;
        total++;
        if (sticky !== 1'b0 || count !== 4'd0)
            $display("FAIL flush_clear: sticky=%b count=%0d required 0 0", sticky, count);
        else passed++;
    endtask

    task automatic test_push_same_cycle();
        logic [TIME_W-1:0] t0;
        do_reset();
        start();
        wait_timer(8'd5);
        t0 = timer;
        push(48'h77, 9'h7, t0);
        wait_fire("same_fire", 5);
        total++;
        if (timer !== t0 + 8'd2 || late !== 1'b1)
            $display("FAIL same_cycle: timer=%0d late=%b required %0d 1", timer, late, t0 + 8'd2);
        else passed++;
    endtask

    task automatic test_equal();
        do_reset();
        for (int i = 1; i <= 3; i++) push(48'(i), 9'(i), 8'd30);
        start();
        wait_fire("equal_fire", 60);
        for (int i = 1; i <= 3; i++) begin
            total++;
            if (evt_valid !== 1'b1 || timer !== 8'(30 + i) || evt_edata !== 48'(i)
                || late !== (i != 1))
                $display("FAIL equal%0d: valid=%b timer=%0d edata=%0d late=%b required 1 %0d %0d %b",
                         i, evt_valid, timer, evt_edata, late, 30 + i, i, i != 1);
            else passed++;
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        start();
        wait_timer(8'd253);
        push(48'h99, 9'h9, 8'd1);
        wait_fire("wrap_fire", 20);
        total++;
        if (timer !== 8'd2 || late !== 1'b0 || evt_edata !== 48'h99)
            $display("FAIL wrap: timer=%0d late=%b edata=%h required 2 0 99", timer, late, evt_edata);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) push(48'(i + 1), 9'(i), 8'(200 + i));
        start();
        tick();
        tick();
        tick();
        tq_stop = 1'b1;
        tick();
        tq_stop = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({evt_valid, late, sticky, evt_edata, evt_oprand, timer, count} !== '0)
            $display("FAIL midreset: valid=%b late=%b sticky=%b edata=%h timer=%0d count=%0d required all 0",
                     evt_valid, late, sticky, evt_edata, timer, count);
        else passed++;
        tick();
        tick();
        total++;
        if (timer !== 8'd0 || evt_valid !== 1'b0)
            $display("FAIL midreset_idle: timer=%0d valid=%b required 0 0", timer, evt_valid);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        tq_start = 1'b0;
        tq_stop = 1'b0;
        tq_flush = 1'b0;
        tq_if.tq_i_valid = 1'b0;
        tq_if.tq_i_edata = '0;
        tq_if.tq_i_oprand = '0;
        tq_if.tq_i_tdata = '0;
        test_reset();
        test_basic();
        test_full();
        test_late_flush();
        test_push_same_cycle();
        test_equal();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
